// File: rtl/pong_pkg.sv
// Shared definitions for the pong pixel-generation stage: screen geometry,
// object geometry and reset positions, colours, the ball state record and a
// small inclusive-range helper. Imported by the interface and all RTL modules.
package pong_pkg;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned RGB_W       = 12;
    localparam int unsigned BALL_W      = 8;
    localparam int unsigned BALL_ROW_AW = 3;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    // Screen
    localparam coord_t H_DISP    = 10'd640;
    localparam coord_t V_DISP    = 10'd480;
    localparam coord_t REFR_LINE = 10'd481;

    // Objects
    localparam coord_t WALL_X_L  = 10'd32;
    localparam coord_t WALL_X_R  = 10'd35;
    localparam coord_t PAD_X_L   = 10'd600;
    localparam coord_t PAD_X_R   = 10'd603;
    localparam coord_t PAD_H     = 10'd72;
    localparam coord_t PAD_V     = 10'd3;
    localparam coord_t BALL_V    = 10'd2;
    localparam coord_t BALL_SIZE = 10'd8;

    // Velocities are 10-bit two's complement
    localparam coord_t BALL_V_NEG = coord_t'(10'd0 - BALL_V);

    // Reset / serve positions (top-left corners)
    localparam coord_t BALL_X_RST = 10'd316;
    localparam coord_t BALL_Y_RST = 10'd236;
    localparam coord_t PAD_Y_RST  = 10'd204;

    // Colours {R4,G4,B4}
    localparam rgb_t C_WALL = 12'h00F;
    localparam rgb_t C_PAD  = 12'h0F0;
    localparam rgb_t C_BALL = 12'hF00;
    localparam rgb_t C_BG   = 12'hFFF;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t dx;
        coord_t dy;
    } ball_t;

    localparam ball_t BALL_RST = '{x: BALL_X_RST, y: BALL_Y_RST, dx: BALL_V, dy: BALL_V};

    // Inclusive range test lo <= v <= hi
    function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pong_graph_if.sv
// Pixel-stage bus between the VGA timing / game-control side (master) and
// pong_graph (slave).
//   video_on, p_tick, x, y     : timing stage -> pixel stage
//   btn_up, btn_down, gra_still: game control -> pixel stage
//   rgb, hit, miss             : pixel stage -> DAC pins / score logic
interface pong_graph_if;
    import pong_pkg::*;

    logic   video_on;
    logic   p_tick;
    coord_t x;
    coord_t y;
    logic   btn_up;
    logic   btn_down;
    logic   gra_still;
    rgb_t   rgb;
    logic   hit;
    logic   miss;

    modport master (
        output video_on, p_tick, x, y, btn_up, btn_down, gra_still,
        input  rgb, hit, miss
    );

    modport slave (
        input  video_on, p_tick, x, y, btn_up, btn_down, gra_still,
        output rgb, hit, miss
    );

endinterface

// File: rtl/pong_graph_ball_rom.sv
// 8x8 round-ball bitmap. Combinational.
//   row_addr : row within the ball, 0 = top
//   row_c    : bitmap row, bit 7 = leftmost pixel
module ball_rom
    import pong_pkg::*;
(
    input  logic [BALL_ROW_AW-1:0] row_addr,
    output logic [BALL_W-1:0]      row_c
);

    always_comb begin
        row_c = '0;
        case (row_addr)
            3'd0: row_c = 8'h3C;
            3'd1: row_c = 8'h7E;
            3'd2: row_c = 8'hFF;
            3'd3: row_c = 8'hFF;
            3'd4: row_c = 8'hFF;
            3'd5: row_c = 8'hFF;
            3'd6: row_c = 8'h7E;
            3'd7: row_c = 8'h3C;
            default: row_c = '0;
        endcase
    end

endmodule

// File: rtl/pong_graph.sv
// Pong pixel-generation stage. Owns the wall, paddle and ball, moves the
// paddle and ball once per frame (on the first clk of x=0,y=481) and drives a
// registered pixel colour one clk after x/y/video_on.
//   clk_100MHz : system clock
//   reset      : asynchronous, active-high
//   bus        : pong_graph_if slave (timing/controls in, rgb/hit/miss out)
module pong_graph
    import pong_pkg::*;
(
    input  logic        clk_100MHz,
    input  logic        reset,
    pong_graph_if.slave bus
);

    logic       frame_cond_c;
    logic       refr_tick_c;
    logic       frame_prev_q, frame_prev_d;
    ball_t      ball_q, ball_d;
    coord_t     pad_y_q, pad_y_d;
    rgb_t       rgb_q, rgb_d;
    logic       hit_q, hit_d;
    logic       miss_q, miss_d;

    coord_t     ball_r_c, ball_b_c, pad_b_c;
    logic       pad_hit_c;
    logic       wall_on_c, pad_on_c, sq_on_c, ball_on_c;
    logic [BALL_ROW_AW-1:0] rom_addr_c;
    logic [BALL_ROW_AW-1:0] bit_sel_c;
    logic [BALL_W-1:0]      rom_row_c;

    // The colour path runs every clk, so the pixel enable is not needed here
    logic       unused_p_tick;
    assign unused_p_tick = bus.p_tick;

    // Frame tick: one clk per frame however long x=0,y=481 is held
    always_comb begin
        frame_cond_c = (bus.x == '0) && (bus.y == REFR_LINE);
        frame_prev_d = frame_cond_c;
        refr_tick_c  = frame_cond_c && !frame_prev_q;
    end

    // Object edges
    always_comb begin
        ball_r_c  = ball_q.x + (BALL_SIZE - 10'd1);
        ball_b_c  = ball_q.y + (BALL_SIZE - 10'd1);
        pad_b_c   = pad_y_q + (PAD_H - 10'd1);
        pad_hit_c = in_span(ball_r_c, PAD_X_L, PAD_X_R)
                 && (pad_y_q <= ball_b_c)
                 && (ball_q.y <= pad_b_c)
                 && !ball_q.dx[COORD_W-1];
    end

    // Paddle: whole steps only, never past the top or bottom edge
    always_comb begin
        pad_y_d = pad_y_q;
        if (refr_tick_c) begin
            if (bus.btn_down && !bus.btn_up && ((pad_b_c + PAD_V) <= (V_DISP - 10'd1))) begin
                pad_y_d = pad_y_q + PAD_V;
            end else if (bus.btn_up && !bus.btn_down && (pad_y_q >= PAD_V)) begin
                pad_y_d = pad_y_q - PAD_V;
            end
        end
    end

    // Ball: move with the current velocity; bounces are decided on the
    // pre-move position and take effect from the next frame
    always_comb begin
        ball_d = ball_q;
        hit_d  = 1'b0;
        miss_d = 1'b0;
        if (refr_tick_c) begin
            if (bus.gra_still) begin
                ball_d = BALL_RST;
            end else begin
                ball_d.x = ball_q.x + ball_q.dx;
                ball_d.y = ball_q.y + ball_q.dy;

                if (ball_q.y <= BALL_V) begin
                    ball_d.dy = BALL_V;
                end else if (ball_b_c >= (V_DISP - 10'd1 - BALL_V)) begin
                    ball_d.dy = BALL_V_NEG;
                end

                if (ball_q.x <= WALL_X_R) begin
                    ball_d.dx = BALL_V;
                end else if (pad_hit_c) begin
                    ball_d.dx = BALL_V_NEG;
                    hit_d     = 1'b1;
                end else if (ball_r_c > (H_DISP - 10'd1)) begin
                    miss_d    = 1'b1;
                end
            end
        end
    end

    // Ball bitmap lookup; low 3 bits of the offsets are the ROM row / column
    always_comb begin
        rom_addr_c = BALL_ROW_AW'(bus.y - ball_q.y);
        bit_sel_c  = 3'd7 - BALL_ROW_AW'(bus.x - ball_q.x);
    end

    ball_rom u_ball_rom (
        .row_addr (rom_addr_c),
        .row_c    (rom_row_c)
    );

    // Colour mux, priority wall > paddle > ball > background
    always_comb begin
        wall_on_c = in_span(bus.x, WALL_X_L, WALL_X_R);
        pad_on_c  = in_span(bus.x, PAD_X_L, PAD_X_R) && in_span(bus.y, pad_y_q, pad_b_c);
        sq_on_c   = in_span(bus.x, ball_q.x, ball_r_c) && in_span(bus.y, ball_q.y, ball_b_c);
        ball_on_c = sq_on_c && rom_row_c[bit_sel_c];

        rgb_d = '0;
        if (!bus.video_on) begin
            rgb_d = '0;
        end else if (wall_on_c) begin
            rgb_d = C_WALL;
        end else if (pad_on_c) begin
            rgb_d = C_PAD;
        end else if (ball_on_c) begin
            rgb_d = C_BALL;
        end else begin
            rgb_d = C_BG;
        end
    end

    // State register
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            frame_prev_q <= 1'b0;
            ball_q       <= BALL_RST;
            pad_y_q      <= PAD_Y_RST;
            rgb_q        <= '0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
        end else begin
            frame_prev_q <= frame_prev_d;
            ball_q       <= ball_d;
            pad_y_q      <= pad_y_d;
            rgb_q        <= rgb_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    assign bus.rgb  = rgb_q;
    assign bus.hit  = hit_q;
    assign bus.miss = miss_q;

endmodule

// File: tb/tb_pong_graph.sv
// Directed bench for pong_graph with a behavioural game model and queued
// expectations for pixel colours and hit/miss pulses.
module tb_pong_graph;
    import pong_pkg::*;

    logic clk_100MHz = 1'b0;
    logic reset;

    always #5 clk_100MHz = ~clk_100MHz;

    pong_graph_if bus ();

    pong_graph dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    rgb_t       exp_rgb_q[$];
    logic [1:0] exp_ev_q[$];

    // Game model
    int m_bx, m_by, m_dx, m_dy, m_pad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bx = 316; m_by = 236; m_dx = 2; m_dy = 2; m_pad = 204;
    endtask

    task automatic model_step(input logic bu, input logic bd, input logic gs,
                              output logic eh, output logic em);
        int br, bb, ndx, ndy;
        eh = 1'b0;
        em = 1'b0;
        br = (m_bx + 7) & 1023;
        bb = (m_by + 7) & 1023;
        ndx = m_dx;
        ndy = m_dy;
        if (gs) begin
            m_bx = 316; m_by = 236; m_dx = 2; m_dy = 2;
        end else begin
            if (m_by <= 2)        ndy = 2;
            else if (bb >= 477)   ndy = -2;
            if (m_bx <= 35) ndx = 2;
            else if (br >= 600 && br <= 603 && m_pad <= bb && m_by <= m_pad + 71 && m_dx > 0) begin
                ndx = -2;
                eh  = 1'b1;
            end else if (br > 639) em = 1'b1;
            m_bx = (m_bx + m_dx) & 1023;
            m_by = (m_by + m_dy) & 1023;
            m_dx = ndx;
            m_dy = ndy;
        end
        if (bd && !bu && m_pad + 74 <= 479)  m_pad = m_pad + 3;
        else if (bu && !bd && m_pad >= 3)    m_pad = m_pad - 3;
    endtask

    task automatic check_state(input string tag);
        ball_t b;
        b = dut.ball_q;
        check({tag, "_ball_x"}, 32'(b.x),  32'(m_bx & 1023));
        check({tag, "_ball_y"}, 32'(b.y),  32'(m_by & 1023));
        check({tag, "_dx"},     32'(b.dx), 32'(m_dx & 1023));
        check({tag, "_dy"},     32'(b.dy), 32'(m_dy & 1023));
        check({tag, "_pad_y"},  32'(dut.pad_y_q), 32'(m_pad));
    endtask

    // Drive one pixel, expect its colour one clk later
    task automatic pix(input string tag, input coord_t px, input coord_t py,
                       input logic vo, input rgb_t exp);
        bus.x = px;
        bus.y = py;
        bus.video_on = vo;
        exp_rgb_q.push_back(exp);
        @(negedge clk_100MHz);
        check(tag, 32'(bus.rgb), 32'(exp_rgb_q.pop_front()));
    endtask

    // One frame update: hold x=0,y=481 for `hold` clks, then leave the line
    task automatic frame(input logic bu, input logic bd, input logic gs, input int hold,
                         output logic eh, output logic em, output logic oh, output logic om);
        logic [1:0] ev;
        model_step(bu, bd, gs, eh, em);
        exp_ev_q.push_back({eh, em});
        bus.btn_up    = bu;
        bus.btn_down  = bd;
        bus.gra_still = gs;
        bus.video_on  = 1'b0;
        bus.x         = 10'd0;
        bus.y         = REFR_LINE;
        @(negedge clk_100MHz);
        ev = exp_ev_q.pop_front();
        oh = bus.hit;
        om = bus.miss;
        check("tick_hit",  32'(bus.hit),  32'(ev[1]));
        check("tick_miss", 32'(bus.miss), 32'(ev[0]));
        for (int i = 1; i < hold; i++) begin
            @(negedge clk_100MHz);
            check("hold_hit",  32'(bus.hit),  32'(1'b0));
            check("hold_miss", 32'(bus.miss), 32'(1'b0));
        end
        bus.x = 10'd1;
        @(negedge clk_100MHz);
        check_state("frame");
    endtask

    initial begin
        logic  eh, em, oh, om;
        logic  bu, bd;
        logic  got;
        int    target;
        ball_t b;

        reset         = 1'b1;
        bus.video_on  = 1'b0;
        bus.p_tick    = 1'b1;
        bus.x         = 10'd100;
        bus.y         = 10'd100;
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.gra_still = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_100MHz);
        check("rst_rgb",  32'(bus.rgb),  32'(0));
        check("rst_hit",  32'(bus.hit),  32'(0));
        check("rst_miss", 32'(bus.miss), 32'(0));
        check_state("rst");
        reset = 1'b0;
        @(negedge clk_100MHz);

        // Pixel mux with ball at (316,236), paddle at 204
        pix("pix_wall",       10'd33,  10'd100, 1'b1, C_WALL);
        pix("pix_ball_r2c4",  10'd320, 10'd238, 1'b1, C_BALL);
        pix("pix_ball_corner",10'd316, 10'd236, 1'b1, C_BG);
        pix("pix_blank",      10'd320, 10'd238, 1'b0, 12'h000);
        pix("pix_pad",        10'd601, 10'd210, 1'b1, C_PAD);
        pix("pix_ball_r7c2",  10'd318, 10'd243, 1'b1, C_BALL);
        pix("pix_ball_r7c7",  10'd323, 10'd243, 1'b1, C_BG);
        pix("pix_past_ball",  10'd324, 10'd240, 1'b1, C_BG);
        pix("pix_below_pad",  10'd601, 10'd276, 1'b1, C_BG);
        pix("pix_bg",         10'd100, 10'd300, 1'b1, C_BG);

        // Frame tick held 8 clks moves the ball exactly once
        frame(1'b0, 1'b0, 1'b0, 8, eh, em, oh, om);
        b = dut.ball_q;
        check("once_x", 32'(b.x), 32'(318));
        check("once_y", 32'(b.y), 32'(238));

        // Mid-frame reset
        pix("pre_rst_bg", 10'd200, 10'd200, 1'b1, C_BG);
        #1 reset = 1'b1;
        #1;
        check("async_rst_rgb",  32'(bus.rgb),  32'(0));
        check("async_rst_hit",  32'(bus.hit),  32'(0));
        check("async_rst_miss", 32'(bus.miss), 32'(0));
        model_reset();
        check_state("async_rst");
        @(negedge clk_100MHz);
        reset = 1'b0;
        #1;
        check("rgb_zero_after_release", 32'(bus.rgb), 32'(0));
        @(negedge clk_100MHz);
        check("post_rst_bg", 32'(bus.rgb), 32'(C_BG));

        // Paddle limits, ball held in the centre
        repeat (100) frame(1'b1, 1'b0, 1'b1, 2, eh, em, oh, om);
        check("pad_top", 32'(dut.pad_y_q), 32'(0));
        repeat (150) frame(1'b0, 1'b1, 1'b1, 2, eh, em, oh, om);
        check("pad_bottom", 32'(dut.pad_y_q), 32'(408));

        // Rally: steer the paddle under the ball until it bounces off
        got = 1'b0;
        for (int f = 0; f < 400 && !got; f++) begin
            target = m_by - 32;
            bu = (m_pad > target + 1);
            bd = (m_pad + 1 < target);
            frame(bu, bd, 1'b0, 2, eh, em, oh, om);
            if (eh) begin
                got = 1'b1;
                b = dut.ball_q;
                check("hit_pulse", 32'(oh), 32'(1));
                check("hit_x",     32'(b.x),  32'(596));
                check("hit_dx",    32'(b.dx), 32'(10'h3FE));
            end
        end
        check("hit_reached", 32'(got), 32'(1));

        // Keep the paddle away until the ball leaves the right edge
        got = 1'b0;
        for (int f = 0; f < 3000 && !got; f++) begin
            target = (m_by < 240) ? 408 : 0;
            bu = (m_pad > target);
            bd = (m_pad < target);
            frame(bu, bd, 1'b0, 2, eh, em, oh, om);
            if (em) begin
                got = 1'b1;
                b = dut.ball_q;
                check("miss_pulse", 32'(om), 32'(1));
                check("miss_x",     32'(b.x), 32'(636));
            end
        end
        check("miss_reached", 32'(got), 32'(1));

        // Serve hold recentres the ball with no pulse
        frame(1'b0, 1'b0, 1'b1, 2, eh, em, oh, om);
        b = dut.ball_q;
        check("recentre_x",    32'(b.x),  32'(316));
        check("recentre_y",    32'(b.y),  32'(236));
        check("recentre_dx",   32'(b.dx), 32'(2));
        check("recentre_miss", 32'(om),   32'(0));

        // Paddle drawn from its final position
        pix("pix_pad_final",  10'd601, 10'(m_pad + 5), 1'b1, C_PAD);
        pix("pix_ball_final", 10'd320, 10'd238,        1'b1, C_BALL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
